fetch_unit: RTL



---
 rtl/proc_pkg.sv | 20 ++
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_unit_next_pc_sel.sv | 45 ++++
 rtl/fetch_unit.sv | 84 ++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared types for the fetch stage: run-state encoding and next-PC select.
package proc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_ABS  = 2'd1,
        SEL_REL  = 2'd2,
        SEL_INC  = 2'd3
    } pc_sel_t;

    localparam int START_ADDR_DEFAULT = 0;

endpackage

// File: rtl/fetch_unit_if.sv
// Control/status bundle between the top level, controlpath and the fetch stage.
interface fetch_unit_if #(
    parameter int PC_W  = 10,
    parameter int OFF_W = 8,
    parameter int CNT_W = 16
);
    logic             START;
    logic             HALT;
    logic             CTRL_branch_rel_nz;
    logic             CTRL_branch_rel_z;
    logic             CTRL_branch_abs;
    logic             ZERO;
    logic [OFF_W-1:0] BR_OFFSET;
    logic [PC_W-1:0]  BR_TARGET;
    logic [PC_W-1:0]  PC;
    logic             RUNNING;
    logic             DONE;
    logic [CNT_W-1:0] INSTR_COUNT;

    modport master (
        output START, HALT, CTRL_branch_rel_nz, CTRL_branch_rel_z, CTRL_branch_abs,
        output ZERO, BR_OFFSET, BR_TARGET,
        input  PC, RUNNING, DONE, INSTR_COUNT
    );

    modport slave (
        input  START, HALT, CTRL_branch_rel_nz, CTRL_branch_rel_z, CTRL_branch_abs,
        input  ZERO, BR_OFFSET, BR_TARGET,
        output PC, RUNNING, DONE, INSTR_COUNT
    );
endinterface

// File: rtl/fetch_unit_next_pc_sel.sv
// Next-PC priority mux: halt > absolute > taken relative > sequential.
module next_pc_sel
    import proc_pkg::*;
#(
    parameter int PC_W  = 10,
    parameter int OFF_W = 8
) (
    input  logic [PC_W-1:0]  pc,
    input  logic             halt,
    input  logic             branch_abs,
    input  logic             branch_rel_z,
    input  logic             branch_rel_nz,
    input  logic             zero,
    input  logic [OFF_W-1:0] br_offset,
    input  logic [PC_W-1:0]  br_target,
    output pc_sel_t          sel,
    output logic [PC_W-1:0]  next_pc
);

    if (OFF_W > PC_W) begin : g_bad_off_w
        $error("next_pc_sel: OFF_W must not exceed PC_W");
    end

    logic [PC_W-1:0] off_ext;

    // Sign-extending size cast; the add below then wraps modulo 2^PC_W.
    assign off_ext = PC_W'($signed(br_offset));

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        sel     = SEL_INC;
        next_pc = pc + PC_W'(1);
        if (halt) begin
            sel     = SEL_HOLD;
            next_pc = pc;
        end else if (branch_abs) begin
            sel     = SEL_ABS;
            next_pc = br_target;
        end else if ((branch_rel_z && zero) || (branch_rel_nz && !zero)) begin
            sel     = SEL_REL;
            next_pc = pc + off_ext;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC, run state and the retired-instruction counter.
module fetch_unit
    import proc_pkg::*;
#(
    parameter int PC_W       = 10,
    parameter int OFF_W      = 8,
    parameter int START_ADDR = START_ADDR_DEFAULT,
    parameter int CNT_W      = 16
) (
    input logic         CLK,
    input logic         RESET_N,
    fetch_unit_if.slave bus
);

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    fetch_state_t     state_q, state_d;
    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  next_pc;
    logic [CNT_W-1:0] cnt_q;
    pc_sel_t          pc_sel;

    next_pc_sel #(
        .PC_W  (PC_W),
        .OFF_W (OFF_W)
    ) u_next_pc_sel (
        .pc            (pc_q),
        .halt          (bus.HALT),
        .branch_abs    (bus.CTRL_branch_abs),
        .branch_rel_z  (bus.CTRL_branch_rel_z),
        .branch_rel_nz (bus.CTRL_branch_rel_nz),
        .zero          (bus.ZERO),
        .br_offset     (bus.BR_OFFSET),
        .br_target     (bus.BR_TARGET),
        .sel           (pc_sel),
        .next_pc       (next_pc)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.START) begin
            state_d = ARM;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                ARM:     state_d = RUN;
                RUN:     state_d = (pc_sel == SEL_HOLD) ? HALTED : RUN;
                HALTED:  state_d = HALTED;
                default: state_d = IDLE;
            endcase
        end
    end

    // PC and counter only move while running; START re-arms from any state.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc_q  <= START_PC;
            cnt_q <= '0;
        end else if (bus.START) begin
            pc_q  <= START_PC;
            cnt_q <= '0;
        end else if (state_q == RUN) begin
            pc_q <= next_pc;
            if (cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.PC          = pc_q;
    assign bus.RUNNING     = (state_q == RUN);
    assign bus.DONE        = (state_q == HALTED);
    assign bus.INSTR_COUNT = cnt_q;

endmodule
